// File: rtl/tsmap_mem_responder.sv
// Dual-port timestamp-map memory: clears itself after every reset, then serves
// shared-strobe read/write requests with a fixed pipelined read latency.
module tsmap_mem_responder #(
  parameter int DVS_WIDTH  = 346,
  parameter int DVS_HEIGHT = 260,
  parameter int WORD_SIZE  = 18,
  parameter int RD_LAT     = 2,
  parameter logic [WORD_SIZE-1:0] INIT_WORD = '0,
  localparam int DEPTH  = DVS_WIDTH * DVS_HEIGHT,
  localparam int W_ADDR = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 rw,
  input  logic [W_ADDR-1:0]    addr_port1,
  input  logic [W_ADDR-1:0]    addr_port2,
  input  logic [WORD_SIZE-1:0] write_data_mem,
  output logic [WORD_SIZE-1:0] read_data1_mem,
  output logic [WORD_SIZE-1:0] read_data2_mem,
  output logic                 read_data_mem_vld1,
  output logic                 read_data_mem_vld2,
  output logic                 ready,
  output logic                 err_drop,
  output logic                 err_oob
);

  localparam logic [W_ADDR:0]   DEPTH_W  = (W_ADDR + 1)'(DEPTH);
  localparam logic [W_ADDR-1:0] LAST_IDX = W_ADDR'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nxt;
  logic [W_ADDR-1:0] cnt;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic req, oob1, oob2, rd_fire, wr_fire;
  logic we;
  logic [W_ADDR-1:0] waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rd1, rd2;

  logic [WORD_SIZE-1:0] pd1 [RD_LAT];
  logic [WORD_SIZE-1:0] pd2 [RD_LAT];
  logic                 pv  [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      S_INIT: if (cnt == LAST_IDX) state_nxt = S_RUN;
      S_RUN:  ready = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (state == S_INIT) cnt <= cnt + 1'b1;
  end

  assign req     = ~cen;
  assign oob1    = {1'b0, addr_port1} >= DEPTH_W;
  assign oob2    = {1'b0, addr_port2} >= DEPTH_W;
  assign rd_fire = ready & req & rw;
  assign wr_fire = ready & req & ~rw & ~oob1;

  // Init sweep owns the write port until RUN; afterwards only in-range writes land.
  always_comb begin
    we    = 1'b0;
    waddr = addr_port1;
    wdata = write_data_mem;
    if (state == S_INIT) begin
      we    = 1'b1;
      waddr = cnt;
      wdata = INIT_WORD;
    end else if (wr_fire) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd1 = oob1 ? INIT_WORD : mem[addr_port1];
  assign rd2 = oob2 ? INIT_WORD : mem[addr_port2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_drop <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      if (req && !ready) err_drop <= 1'b1;
      if (ready && req && (oob1 || (rw && oob2))) err_oob <= 1'b1;
    end
  end

  // Data is captured at issue so later writes cannot alter an in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i]  <= 1'b0;
        pd1[i] <= '0;
        pd2[i] <= '0;
      end
      read_data1_mem     <= '0;
      read_data2_mem     <= '0;
      read_data_mem_vld1 <= 1'b0;
      read_data_mem_vld2 <= 1'b0;
    end else begin
      pv[0] <= rd_fire;
      if (rd_fire) begin
        pd1[0] <= rd1;
        pd2[0] <= rd2;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pd1[i] <= pd1[i-1];
        pd2[i] <= pd2[i-1];
      end
      read_data_mem_vld1 <= pv[RD_LAT-1];
      read_data_mem_vld2 <= pv[RD_LAT-1];
      if (pv[RD_LAT-1]) begin
        read_data1_mem <= pd1[RD_LAT-1];
        read_data2_mem <= pd2[RD_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_tsmap_mem_responder.sv
// Scoreboard bench for tsmap_mem_responder on a 4x3 map: reads push expected
// words and arrival cycle; a negedge monitor pops and compares on every valid.
module tb_tsmap_mem_responder;

  localparam int WS  = 18;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst, cen, rw;
  logic [3:0] a1, a2;
  logic [WS-1:0] wd;
  logic [WS-1:0] d1, d2;
  logic vld1, vld2, ready, err_drop, err_oob;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [WS-1:0] d1;
    logic [WS-1:0] d2;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  tsmap_mem_responder #(
    .DVS_WIDTH(4), .DVS_HEIGHT(3), .WORD_SIZE(WS), .RD_LAT(LAT), .INIT_WORD(18'h0)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .rw(rw),
    .addr_port1(a1), .addr_port2(a2), .write_data_mem(wd),
    .read_data1_mem(d1), .read_data2_mem(d2),
    .read_data_mem_vld1(vld1), .read_data_mem_vld2(vld2),
    .ready(ready), .err_drop(err_drop), .err_oob(err_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (vld1 || vld2) begin
      exp_t e;
      chk("vld_pair", {31'b0, vld2}, {31'b0, vld1});
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0b/%0b required=0/0 (cycle %0d)", vld1, vld2, cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data1", {14'b0, d1}, {14'b0, e.d1});
        chk("rd_data2", {14'b0, d2}, {14'b0, e.d2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [WS-1:0] d);
    cen = 1'b0; rw = 1'b0; a1 = a; a2 = 4'd0; wd = d;
    tick();
    cen = 1'b1;
  endtask

  task automatic rd(logic [3:0] x, logic [3:0] y, logic [WS-1:0] e1, logic [WS-1:0] e2);
    exp_t e;
    e.d1 = e1; e.d2 = e2; e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    cen = 1'b0; rw = 1'b1; a1 = x; a2 = y;
    tick();
    cen = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    cen = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) tick();
  endtask

  function automatic logic [WS-1:0] final_word(int a);
    if (a == 5) return 18'h20001;
    if (a == 2) return 18'h00007;
    return 18'h0;
  endfunction

  initial begin
    rst = 1'b1; cen = 1'b1; rw = 1'b1; a1 = '0; a2 = '0; wd = '0;
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_vld2", vld2, 0);
    chk("rst_data1", d1, 0);
    chk("rst_data2", d2, 0);
    chk("rst_err_drop", err_drop, 0);
    chk("rst_err_oob", err_oob, 0);
    tick(); tick();
    rst = 1'b0;

    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("ready_edge", ready, (e == 12) ? 1 : 0);
    end
    chk("init_err_drop", err_drop, 0);

    // sweep: port1 ascending, port2 descending, all cleared
    for (int i = 0; i < 12; i++) rd(4'(i), 4'(11 - i), 18'h0, 18'h0);
    drain();
    chk("sweep_err_oob", err_oob, 0);

    // read-after-write on both ports
    wr(4'd5, 18'h1ABCD);
    rd(4'd5, 4'd5, 18'h1ABCD, 18'h1ABCD);
    drain();

    // mixed stream keeps issue order
    wr(4'd5, 18'h20001);
    rd(4'd5, 4'd2, 18'h20001, 18'h0);
    drain();
    chk("pre_oob_err_oob", err_oob, 0);

    wr(4'd2, 18'h00007);
    rd(4'd13, 4'd2, 18'h0, 18'h00007);
    drain();
    chk("oob_read_err_oob", err_oob, 1);

    wr(4'd15, 18'h3FFFF);
    rd(4'd15, 4'd15, 18'h0, 18'h0);
    for (int i = 0; i < 12; i++) rd(4'(i), 4'(i), final_word(i), final_word(i));
    drain();
    chk("run_err_drop", err_drop, 0);
    chk("run_err_oob", err_oob, 1);

    // read in flight when reset hits: must never emerge
    cen = 1'b0; rw = 1'b1; a1 = 4'd5; a2 = 4'd5;
    tick();
    cen = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 0);
    chk("abort_err_oob", err_oob, 0);
    tick(); tick();
    rst = 1'b0;

    tick(); tick();
    chk("pre_drop_err_drop", err_drop, 0);
    cen = 1'b0; rw = 1'b1; a1 = 4'd0; a2 = 4'd0;
    tick();
    cen = 1'b1;
    chk("drop_err_drop", err_drop, 1);
    for (int e = 4; e <= 12; e++) begin
      tick();
      chk("reinit_ready_edge", ready, (e == 12) ? 1 : 0);
    end

    rd(4'd5, 4'd5, 18'h0, 18'h0);
    rd(4'd2, 4'd2, 18'h0, 18'h0);
    drain();
    chk("sticky_err_drop", err_drop, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
